// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Holds the FSM state and owner enums, bus widths and the legal store-mask set.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [MASK_W-1:0] mask_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam mask_t MASK_BYTE  = 8'h01;
    localparam mask_t MASK_HALF  = 8'h03;
    localparam mask_t MASK_WORD  = 8'h0F;
    localparam mask_t MASK_DWORD = 8'hFF;

    // Request captured at handshake and held for the whole transaction
    typedef struct packed {
        owner_e owner;
        addr_t  addr;
        logic   we;
        data_t  wdata;
        mask_t  wmask;
    } req_t;

    function automatic logic mask_legal(input mask_t m);
        return (m == MASK_BYTE) || (m == MASK_HALF) || (m == MASK_WORD) || (m == MASK_DWORD);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between IFU and LSU with a last-grant register.
// A grant is only issued while enabled and always implies the matching request.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_ifu,
    input  logic i_req_lsu,
    output logic o_gnt_ifu_c,
    output logic o_gnt_lsu_c
);

    owner_e r_last;

    // After reset LSU counts as last granted, so IFU wins the first tie
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= OWN_LSU;
        end else if (o_gnt_ifu_c || o_gnt_lsu_c) begin
            r_last <= o_gnt_ifu_c ? OWN_IFU : OWN_LSU;
        end
    end

    always_comb begin
        o_gnt_ifu_c = 1'b0;
        o_gnt_lsu_c = 1'b0;
        if (i_en) begin
            if (i_req_ifu && i_req_lsu) begin
                o_gnt_ifu_c = (r_last == OWN_LSU);
                o_gnt_lsu_c = (r_last == OWN_IFU);
            end else begin
                o_gnt_ifu_c = i_req_ifu;
                o_gnt_lsu_c = i_req_lsu;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter: IFU reads and LSU loads/stores share one memory port.
// Optional store-mask checking is enabled by defining MEM_ARB_MASK_CHECK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready_c,
    input  logic [ADDR_W-1:0] i_ifu_req_addr,
    output logic              o_ifu_resp_valid,
    output logic [DATA_W-1:0] o_ifu_resp_data,
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready_c,
    input  logic [ADDR_W-1:0] i_lsu_req_addr,
    input  logic              i_lsu_req_we,
    input  logic [DATA_W-1:0] i_lsu_req_wdata,
    input  logic [MASK_W-1:0] i_lsu_req_wmask,
    output logic              o_lsu_resp_valid,
    output logic [DATA_W-1:0] o_lsu_resp_data,
    output logic              o_lsu_resp_err,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_mem_we_en,
    output logic [ADDR_W-1:0] o_mem_we_addr,
    output logic [DATA_W-1:0] o_mem_we_data,
    output logic [MASK_W-1:0] o_mem_we_mask
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    req_t              r_req;
    logic              r_bad;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_ifu_resp_valid;
    logic              r_lsu_resp_valid;
    logic              r_lsu_resp_err;
    logic              r_mem_rd_en;
    logic              r_mem_we_en;

    state_e            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    req_t              w_req_nxt;
    logic              w_bad_nxt;
    logic [DATA_W-1:0] w_resp_data_nxt;
    logic              w_ifu_resp_valid_nxt;
    logic              w_lsu_resp_valid_nxt;
    logic              w_lsu_resp_err_nxt;
    logic              w_mem_rd_en_nxt;
    logic              w_mem_we_en_nxt;
    logic              w_arb_en;
    logic              w_gnt_ifu;
    logic              w_gnt_lsu;
    logic              w_mask_bad;

    // Grants only in IDLE and never while reset is held
    assign w_arb_en = (r_state == ST_IDLE) && i_rst_n;

    rr_arb2 u_rr_arb2 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (w_arb_en),
        .i_req_ifu   (i_ifu_req_valid),
        .i_req_lsu   (i_lsu_req_valid),
        .o_gnt_ifu_c (w_gnt_ifu),
        .o_gnt_lsu_c (w_gnt_lsu)
    );

`ifdef MEM_ARB_MASK_CHECK_EN
    assign w_mask_bad = i_lsu_req_we && !mask_legal(i_lsu_req_wmask);
`else
    assign w_mask_bad = 1'b0;
`endif

    // Enables and response pulses are registered from next-state lookahead
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_req_nxt            = r_req;
        w_bad_nxt            = r_bad;
        w_resp_data_nxt      = r_resp_data;
        w_ifu_resp_valid_nxt = 1'b0;
        w_lsu_resp_valid_nxt = 1'b0;
        w_lsu_resp_err_nxt   = 1'b0;
        w_mem_rd_en_nxt      = 1'b0;
        w_mem_we_en_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_ifu || w_gnt_lsu) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    if (w_gnt_ifu) begin
                        w_req_nxt.owner = OWN_IFU;
                        w_req_nxt.addr  = i_ifu_req_addr;
                        w_req_nxt.we    = 1'b0;
                        w_req_nxt.wdata = '0;
                        w_req_nxt.wmask = '0;
                        w_bad_nxt       = 1'b0;
                    end else begin
                        w_req_nxt.owner = OWN_LSU;
                        w_req_nxt.addr  = i_lsu_req_addr;
                        w_req_nxt.we    = i_lsu_req_we;
                        w_req_nxt.wdata = i_lsu_req_wdata;
                        w_req_nxt.wmask = i_lsu_req_wmask;
                        w_bad_nxt       = w_mask_bad;
                    end
                    w_mem_rd_en_nxt = !w_req_nxt.we;
                    w_mem_we_en_nxt = w_req_nxt.we && !w_bad_nxt;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt          = ST_RESP;
                    w_resp_data_nxt      = r_req.we ? '0 : i_mem_rd_data;
                    w_ifu_resp_valid_nxt = (r_req.owner == OWN_IFU);
                    w_lsu_resp_valid_nxt = (r_req.owner == OWN_LSU);
                    w_lsu_resp_err_nxt   = (r_req.owner == OWN_LSU) && r_bad;
                end else begin
                    w_cnt_nxt       = r_cnt - CNT_W'(1);
                    w_mem_rd_en_nxt = !r_req.we;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_req            <= '0;
            r_bad            <= 1'b0;
            r_resp_data      <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            r_mem_rd_en      <= 1'b0;
            r_mem_we_en      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_req            <= w_req_nxt;
            r_bad            <= w_bad_nxt;
            r_resp_data      <= w_resp_data_nxt;
            r_ifu_resp_valid <= w_ifu_resp_valid_nxt;
            r_lsu_resp_valid <= w_lsu_resp_valid_nxt;
            r_lsu_resp_err   <= w_lsu_resp_err_nxt;
            r_mem_rd_en      <= w_mem_rd_en_nxt;
            r_mem_we_en      <= w_mem_we_en_nxt;
        end
    end

    assign o_ifu_req_ready_c = w_gnt_ifu;
    assign o_lsu_req_ready_c = w_gnt_lsu;
    assign o_ifu_resp_valid  = r_ifu_resp_valid;
    assign o_ifu_resp_data   = r_resp_data;
    assign o_lsu_resp_valid  = r_lsu_resp_valid;
    assign o_lsu_resp_data   = r_resp_data;
    assign o_lsu_resp_err    = r_lsu_resp_err;
    assign o_mem_rd_en       = r_mem_rd_en;
    assign o_mem_rd_addr     = r_req.addr;
    assign o_mem_we_en       = r_mem_we_en;
    assign o_mem_we_addr     = r_req.addr;
    assign o_mem_we_data     = r_req.wdata;
    assign o_mem_we_mask     = r_req.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with LATENCY=1 and one with LATENCY=3.
// Directed sequences, an arbitration vector table and a randomized run against a cycle-schedule model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic  clk;
    logic  rst_n           [2];
    logic  ifu_req_valid   [2];
    logic  ifu_req_ready   [2];
    addr_t ifu_req_addr    [2];
    logic  ifu_resp_valid  [2];
    data_t ifu_resp_data   [2];
    logic  lsu_req_valid   [2];
    logic  lsu_req_ready   [2];
    addr_t lsu_req_addr    [2];
    logic  lsu_req_we      [2];
    data_t lsu_req_wdata   [2];
    mask_t lsu_req_wmask   [2];
    logic  lsu_resp_valid  [2];
    data_t lsu_resp_data   [2];
    logic  lsu_resp_err    [2];
    logic  mem_rd_en       [2];
    addr_t mem_rd_addr     [2];
    data_t mem_rd_data     [2];
    logic  mem_we_en       [2];
    addr_t mem_we_addr     [2];
    data_t mem_we_data     [2];
    mask_t mem_we_mask     [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int    resp_at;
        data_t rdata;
        logic  rerr;
        int    we_cnt;
        int    rd_cnt;
        mask_t we_mask;
        data_t we_data;
        addr_t we_addr;
        int    wrong;
    } obs_t;

    typedef struct {
        bit iv;
        bit lv;
        bit exp_ir;
        bit exp_lr;
    } arb_vec_t;

    function automatic data_t rd_func(input addr_t a);
        if (a == 64'h0000_0000_8000_0000) return 64'h1122_3344_5566_7788;
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit legal_mask(input mask_t m);
        return (m == 8'h01) || (m == 8'h03) || (m == 8'h0F) || (m == 8'hFF);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.LATENCY((g == 0) ? 1 : 3)) u_dut (
            .i_clk             (clk),
            .i_rst_n           (rst_n[g]),
            .i_ifu_req_valid   (ifu_req_valid[g]),
            .o_ifu_req_ready_c (ifu_req_ready[g]),
            .i_ifu_req_addr    (ifu_req_addr[g]),
            .o_ifu_resp_valid  (ifu_resp_valid[g]),
            .o_ifu_resp_data   (ifu_resp_data[g]),
            .i_lsu_req_valid   (lsu_req_valid[g]),
            .o_lsu_req_ready_c (lsu_req_ready[g]),
            .i_lsu_req_addr    (lsu_req_addr[g]),
            .i_lsu_req_we      (lsu_req_we[g]),
            .i_lsu_req_wdata   (lsu_req_wdata[g]),
            .i_lsu_req_wmask   (lsu_req_wmask[g]),
            .o_lsu_resp_valid  (lsu_resp_valid[g]),
            .o_lsu_resp_data   (lsu_resp_data[g]),
            .o_lsu_resp_err    (lsu_resp_err[g]),
            .o_mem_rd_en       (mem_rd_en[g]),
            .o_mem_rd_addr     (mem_rd_addr[g]),
            .i_mem_rd_data     (mem_rd_data[g]),
            .o_mem_we_en       (mem_we_en[g]),
            .o_mem_we_addr     (mem_we_addr[g]),
            .o_mem_we_data     (mem_we_data[g]),
            .o_mem_we_mask     (mem_we_mask[g])
        );
        assign mem_rd_data[g] = rd_func(mem_rd_addr[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input int d, input bit iv, input addr_t ia, input bit lv, input addr_t la,
                          input bit we, input data_t wd, input mask_t wm);
        ifu_req_valid[d] = iv;
        ifu_req_addr[d]  = ia;
        lsu_req_valid[d] = lv;
        lsu_req_addr[d]  = la;
        lsu_req_we[d]    = we;
        lsu_req_wdata[d] = wd;
        lsu_req_wmask[d] = wm;
    endtask

    // Valids are held high during reset to show ready stays low
    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        set_in(d, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0100, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        check($sformatf("rst%0d_ifu_ready", d), ifu_req_ready[d], 1'b0);
        check($sformatf("rst%0d_lsu_ready", d), lsu_req_ready[d], 1'b0);
        check($sformatf("rst%0d_resp_valid", d), {ifu_resp_valid[d], lsu_resp_valid[d], lsu_resp_err[d]}, 3'b000);
        check($sformatf("rst%0d_mem_en", d), {mem_rd_en[d], mem_we_en[d]}, 2'b00);
        check($sformatf("rst%0d_latched", d), mem_rd_addr[d] | mem_we_data[d] | 64'(mem_we_mask[d]), 64'h0);
        @(negedge clk);
        rst_n[d] = 1'b1;
        set_in(d, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic run_txn(input int d, input bit lsu, input bit we, input addr_t a, input data_t wd,
                           input mask_t wm, output obs_t o);
        o.resp_at = -1;
        o.rdata   = '0;
        o.rerr    = 1'b0;
        o.we_cnt  = 0;
        o.rd_cnt  = 0;
        o.we_mask = '0;
        o.we_data = '0;
        o.we_addr = '0;
        o.wrong   = 0;
        @(negedge clk);
        if (lsu) set_in(d, 1'b0, '0, 1'b1, a, we, wd, wm);
        else     set_in(d, 1'b1, a, 1'b0, '0, 1'b0, '0, '0);
        #1;
        check("txn_hs_ready", lsu ? lsu_req_ready[d] : ifu_req_ready[d], 1'b1);
        for (int k = 1; k <= 20; k++) begin
            logic own;
            logic oth;
            @(negedge clk);
            set_in(d, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
            #1;
            if (mem_we_en[d]) begin
                o.we_cnt++;
                o.we_mask = mem_we_mask[d];
                o.we_data = mem_we_data[d];
                o.we_addr = mem_we_addr[d];
            end
            if (mem_rd_en[d]) begin
                o.rd_cnt++;
                if (mem_rd_addr[d] !== a) o.wrong++;
            end
            own = lsu ? lsu_resp_valid[d] : ifu_resp_valid[d];
            oth = lsu ? ifu_resp_valid[d] : lsu_resp_valid[d];
            if (oth) o.wrong++;
            if (own) begin
                if (o.resp_at < 0) begin
                    o.resp_at = k;
                    o.rdata   = lsu ? lsu_resp_data[d] : ifu_resp_data[d];
                    o.rerr    = lsu_resp_err[d];
                end else begin
                    o.wrong++;
                end
            end
        end
    endtask

    // Reference: per-transaction schedule (handshake cycle h, BUSY h+1..h+L, RESP h+L+1)
    task automatic rand_run(input int d, input int n);
        int    lat;
        int    h;
        bit    own_lsu;
        bit    t_we;
        bit    t_err;
        addr_t t_addr;
        data_t t_exp;
        data_t t_wd;
        mask_t t_wm;
        bit    last_lsu;
        lat = lat_of(d);
        h = -1000;
        own_lsu = 1'b0;
        t_we = 1'b0;
        t_err = 1'b0;
        t_addr = '0;
        t_exp = '0;
        t_wd = '0;
        t_wm = '0;
        last_lsu = 1'b1;
        for (int c = 0; c < n; c++) begin
            bit    iv, lv, lwe, idle, gi, gl, rd_exp, we_exp, irv, lrv;
            addr_t ia, la;
            data_t wd;
            mask_t wm;
            mask_t legal [4];
            legal[0] = 8'h01; legal[1] = 8'h03; legal[2] = 8'h0F; legal[3] = 8'hFF;
            @(negedge clk);
            iv  = ($urandom % 4) != 0;
            lv  = ($urandom % 4) != 0;
            lwe = ($urandom % 2) != 0;
            ia  = {$urandom, $urandom};
            la  = {$urandom, $urandom};
            wd  = {$urandom, $urandom};
            wm  = (($urandom % 2) != 0) ? legal[$urandom % 4] : 8'($urandom);
            set_in(d, iv, ia, lv, la, lwe, wd, wm);
            #1;
            idle = (c >= h + lat + 2);
            gi = 1'b0;
            gl = 1'b0;
            if (idle) begin
                if (iv && lv) begin
                    gi = last_lsu;
                    gl = !last_lsu;
                end else begin
                    gi = iv;
                    gl = lv;
                end
            end
            check($sformatf("rnd%0d_c%0d_ready", d, c), {ifu_req_ready[d], lsu_req_ready[d]}, {gi, gl});
            rd_exp = !t_we && (c >= h + 1) && (c <= h + lat);
            check($sformatf("rnd%0d_c%0d_rd_en", d, c), mem_rd_en[d], rd_exp);
            if (rd_exp) check($sformatf("rnd%0d_c%0d_rd_addr", d, c), mem_rd_addr[d], t_addr);
            we_exp = t_we && !t_err && (c == h + 1);
            check($sformatf("rnd%0d_c%0d_we_en", d, c), mem_we_en[d], we_exp);
            if (t_we && c == h + 1) begin
                check($sformatf("rnd%0d_c%0d_we_addr", d, c), mem_we_addr[d], t_addr);
                check($sformatf("rnd%0d_c%0d_we_data", d, c), mem_we_data[d], t_wd);
                check($sformatf("rnd%0d_c%0d_we_mask", d, c), mem_we_mask[d], t_wm);
            end
            irv = (c == h + lat + 1) && !own_lsu;
            lrv = (c == h + lat + 1) && own_lsu;
            check($sformatf("rnd%0d_c%0d_resp_valid", d, c), {ifu_resp_valid[d], lsu_resp_valid[d]}, {irv, lrv});
            check($sformatf("rnd%0d_c%0d_resp_err", d, c), lsu_resp_err[d], lrv && t_err);
            if (irv) check($sformatf("rnd%0d_c%0d_ifu_data", d, c), ifu_resp_data[d], t_exp);
            if (lrv) check($sformatf("rnd%0d_c%0d_lsu_data", d, c), lsu_resp_data[d], t_exp);
            if (gi || gl) begin
                h        = c;
                own_lsu  = gl;
                t_we     = gl && lwe;
                t_addr   = gi ? ia : la;
                t_wd     = gl ? wd : '0;
                t_wm     = gl ? wm : '0;
`ifdef MEM_ARB_MASK_CHECK_EN
                t_err    = t_we && !legal_mask(wm);
`else
                t_err    = 1'b0;
`endif
                t_exp    = t_we ? '0 : rd_func(t_addr);
                last_lsu = gl;
            end
        end
        set_in(d, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        obs_t     o;
        arb_vec_t tbl [10];
        int       pulses;

        tbl[0] = '{1, 1, 1, 0};
        tbl[1] = '{1, 1, 0, 1};
        tbl[2] = '{1, 1, 1, 0};
        tbl[3] = '{0, 1, 0, 1};
        tbl[4] = '{0, 1, 0, 1};
        tbl[5] = '{1, 1, 1, 0};
        tbl[6] = '{1, 0, 1, 0};
        tbl[7] = '{1, 1, 0, 1};
        tbl[8] = '{0, 0, 0, 0};
        tbl[9] = '{1, 1, 1, 0};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            set_in(d, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        end
        do_reset(0);
        do_reset(1);

        // IFU read with LATENCY=1
        run_txn(0, 1'b0, 1'b0, 64'h8000_0000, '0, '0, o);
        check("ifu_rd_latency", 64'(o.resp_at), 64'd2);
        check("ifu_rd_data", o.rdata, 64'h1122_3344_5566_7788);
        check("ifu_rd_en_cycles", 64'(o.rd_cnt), 64'd1);
        check("ifu_rd_stray", 64'(o.wrong + o.we_cnt), 64'd0);

        // LSU write with legal mask, LATENCY=3
        run_txn(1, 1'b1, 1'b1, 64'h8000_0200, 64'hDEAD_BEEF, 8'h0F, o);
        check("lsu_wr_we_cycles", 64'(o.we_cnt), 64'd1);
        check("lsu_wr_latency", 64'(o.resp_at), 64'd4);
        check("lsu_wr_data_zero", o.rdata, 64'h0);
        check("lsu_wr_err", o.rerr, 1'b0);
        check("lsu_wr_port", {o.we_addr, o.we_data}, {64'h8000_0200, 64'hDEAD_BEEF});
        check("lsu_wr_mask", o.we_mask, 8'h0F);
        check("lsu_wr_stray", 64'(o.wrong + o.rd_cnt), 64'd0);

        // LSU read, LATENCY=3
        run_txn(1, 1'b1, 1'b0, 64'h8000_0100, '0, '0, o);
        check("lsu_rd_latency", 64'(o.resp_at), 64'd4);
        check("lsu_rd_data", o.rdata, rd_func(64'h8000_0100));
        check("lsu_rd_en_cycles", 64'(o.rd_cnt), 64'd3);
        check("lsu_rd_stray", 64'(o.wrong + o.we_cnt), 64'd0);

        // Store with an illegal byte mask
        run_txn(1, 1'b1, 1'b1, 64'h8000_0300, 64'h0102_0304, 8'h05, o);
        check("mask05_latency", 64'(o.resp_at), 64'd4);
        check("mask05_port_mask", mem_we_mask[1], 8'h05);
`ifdef MEM_ARB_MASK_CHECK_EN
        check("mask05_we_cycles", 64'(o.we_cnt), 64'd0);
        check("mask05_err", o.rerr, 1'b1);
`else
        check("mask05_we_cycles", 64'(o.we_cnt), 64'd1);
        check("mask05_we_mask", o.we_mask, 8'h05);
        check("mask05_err", o.rerr, 1'b0);
`endif

        // Reset during BUSY of a write aborts it
        @(negedge clk);
        set_in(1, 1'b0, '0, 1'b1, 64'h8000_0200, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        #1;
        check("abort_hs", lsu_req_ready[1], 1'b1);
        @(negedge clk);
        set_in(1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        #1;
        check("abort_we_first", mem_we_en[1], 1'b1);
        @(negedge clk);
        rst_n[1] = 1'b0;
        set_in(1, 1'b1, 64'h8000_0040, 1'b0, '0, 1'b0, '0, '0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (ifu_resp_valid[1] || lsu_resp_valid[1] || mem_we_en[1] || lsu_resp_err[1] ||
                ifu_req_ready[1] || lsu_req_ready[1]) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        set_in(1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        run_txn(1, 1'b0, 1'b0, 64'h8000_0040, '0, '0, o);
        check("abort_next_latency", 64'(o.resp_at), 64'd4);
        check("abort_next_data", o.rdata, rd_func(64'h8000_0040));

        // Arbitration table from reset, valids held through each transaction
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(1, tbl[i].iv, 64'h8000_0000, tbl[i].lv, 64'h8000_0100, 1'b0, '0, '0);
            #1;
            check($sformatf("tbl%0d_ready", i), {ifu_req_ready[1], lsu_req_ready[1]}, {tbl[i].exp_ir, tbl[i].exp_lr});
            if (tbl[i].exp_ir || tbl[i].exp_lr) begin
                for (int k = 1; k <= lat_of(1) + 1; k++) begin
                    @(negedge clk);
                    #1;
                    check($sformatf("tbl%0d_k%0d_ready_low", i, k), {ifu_req_ready[1], lsu_req_ready[1]}, 2'b00);
                end
                check($sformatf("tbl%0d_resp", i), {ifu_resp_valid[1], lsu_resp_valid[1]}, {tbl[i].exp_ir, tbl[i].exp_lr});
                check($sformatf("tbl%0d_data", i), tbl[i].exp_ir ? ifu_resp_data[1] : lsu_resp_data[1],
                      tbl[i].exp_ir ? rd_func(64'h8000_0000) : rd_func(64'h8000_0100));
            end
        end
        @(negedge clk);
        set_in(1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

        // Randomized traffic on both latencies
        do_reset(0);
        rand_run(0, 300);
        do_reset(1);
        rand_run(1, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
